// File: rtl/btb_update_sched.sv
// BTB write scheduler: queues EX branch updates, issues one per cycle with a same-set bubble,
// and runs a full clear sweep on flush. Optional counters under BTB_SCHED_STATS_EN.
module btb_update_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SETS   = 8,
    parameter int INDEX_W    = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 br_valid,
    input  logic [31:0]                          br_pc,
    input  logic [31:0]                          br_target,
    input  logic                                 br_mispredicted,
    output logic                                 br_ready,
    input  logic                                 flush_req,
    output logic                                 flush_busy,
    output logic                                 btb_update,
    output logic [31:0]                          btb_update_pc,
    output logic [31:0]                          btb_update_target,
    output logic                                 btb_mispredicted,
    output logic                                 btb_clear,
    output logic [INDEX_W-1:0]                   btb_clear_index,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
`ifdef BTB_SCHED_STATS_EN
    ,
    output logic [31:0]                          stat_issued,
    output logic [31:0]                          stat_hazard
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state;
    logic [31:0]          q_pc  [FIFO_DEPTH];
    logic [31:0]          q_tgt [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_mis;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic                 last_valid;
    logic [INDEX_W-1:0]   last_index;
    logic [INDEX_W-1:0]   head_index;
    logic                 push;
    logic                 head_ready;
    logic                 hazard;
    logic                 issue;
    logic                 bubble;

    // A transfer happens on any cycle where br_valid and br_ready are both high at the clock edge;
    // br_ready never depends on br_valid, and there is no bypass around a full queue.
    assign br_ready = (fifo_count < CNT_W'(FIFO_DEPTH)) && !flush_busy && !flush_req;
    assign push     = br_valid && br_ready;

    assign head_index = q_pc[rd_ptr][INDEX_W+1:2];
    assign head_ready = (state != FLUSH) && !flush_req && (fifo_count != '0);
    // The BTB write lands a cycle late, so a same-set follow-on must wait one cycle.
    assign hazard     = last_valid && (head_index == last_index);
    assign issue      = head_ready && !hazard;
    assign bubble     = head_ready && hazard;

    always_comb begin
        count_next = fifo_count;
        if (push && !issue) begin
            count_next = fifo_count + 1'b1;
        end else if (!push && issue) begin
            count_next = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= br_pc;
            q_tgt[wr_ptr] <= br_target;
            q_mis[wr_ptr] <= br_mispredicted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
            last_valid        <= 1'b0;
            last_index        <= '0;
            flush_busy        <= 1'b0;
            btb_update        <= 1'b0;
            btb_update_pc     <= '0;
            btb_update_target <= '0;
            btb_mispredicted  <= 1'b0;
            btb_clear         <= 1'b0;
            btb_clear_index   <= '0;
        end else if (flush_req) begin
            // Flush from any state (including mid-sweep) discards the queue and restarts at set 0.
            state             <= FLUSH;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
            last_valid        <= 1'b0;
            flush_busy        <= 1'b1;
            btb_update        <= 1'b0;
            btb_update_pc     <= '0;
            btb_update_target <= '0;
            btb_mispredicted  <= 1'b0;
            btb_clear         <= 1'b1;
            btb_clear_index   <= '0;
        end else if (state == FLUSH) begin
            btb_update <= 1'b0;
            if (btb_clear_index == INDEX_W'(NUM_SETS - 1)) begin
                state           <= IDLE;
                flush_busy      <= 1'b0;
                btb_clear       <= 1'b0;
                btb_clear_index <= '0;
            end else begin
                btb_clear_index <= btb_clear_index + 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr            <= rd_ptr + 1'b1;
                btb_update        <= 1'b1;
                btb_update_pc     <= q_pc[rd_ptr];
                btb_update_target <= q_tgt[rd_ptr];
                btb_mispredicted  <= q_mis[rd_ptr];
                last_valid        <= 1'b1;
                last_index        <= head_index;
            end else begin
                btb_update        <= 1'b0;
                btb_update_pc     <= '0;
                btb_update_target <= '0;
                btb_mispredicted  <= 1'b0;
                last_valid        <= 1'b0;
            end
            fifo_count <= count_next;
            state      <= (count_next != '0) ? ISSUE : IDLE;
        end
    end

`ifdef BTB_SCHED_STATS_EN
    // Saturating event counters; only reset clears them, flush does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_hazard <= '0;
        end else begin
            if (issue && (stat_issued != 32'hFFFF_FFFF)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (bubble && (stat_hazard != 32'hFFFF_FFFF)) begin
                stat_hazard <= stat_hazard + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_sched.sv
// Directed bench for btb_update_sched: update ordering, same-set bubble, backpressure,
// flush sweep, sweep restart and async reset abort.
module tb_btb_update_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_target = '0;
    logic        br_mispredicted = 1'b0;
    logic        br_ready;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        btb_update;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_target;
    logic        btb_mispredicted;
    logic        btb_clear;
    logic [2:0]  btb_clear_index;
    logic [2:0]  fifo_count;
`ifdef BTB_SCHED_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_hazard;
`endif

    btb_update_sched dut (
        .clk               (clk),
        .rst               (rst),
        .br_valid          (br_valid),
        .br_pc             (br_pc),
        .br_target         (br_target),
        .br_mispredicted   (br_mispredicted),
        .br_ready          (br_ready),
        .flush_req         (flush_req),
        .flush_busy        (flush_busy),
        .btb_update        (btb_update),
        .btb_update_pc     (btb_update_pc),
        .btb_update_target (btb_update_target),
        .btb_mispredicted  (btb_mispredicted),
        .btb_clear         (btb_clear),
        .btb_clear_index   (btb_clear_index),
        .fifo_count        (fifo_count)
`ifdef BTB_SCHED_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_hazard       (stat_hazard)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [64:0] exp_q[$];
    int          obs_cyc[$];
    logic [2:0]  clr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every update must match the oldest accepted entry
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst && btb_update) begin
            obs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_update", 72'(btb_update), 72'(0));
            end else begin
                e = exp_q.pop_front();
                check("update", {7'd0, btb_mispredicted, btb_update_target, btb_update_pc}, {7'd0, e});
            end
        end
        if (!rst && btb_clear) clr_q.push_back(btb_clear_index);
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        br_valid = 1'b0;
        step(n);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic mis);
        bit done;
        done = 1'b0;
        br_valid = 1'b1;
        br_pc = pc;
        br_target = tgt;
        br_mispredicted = mis;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (br_ready) begin
                exp_q.push_back({mis, tgt, pc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("push_timeout", 72'(done), 72'(1));
    endtask

    initial begin
        int base;
`ifdef BTB_SCHED_STATS_EN
        logic [31:0] h0;
`endif
        // 1: reset state
        step(3);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("rst_ready", 72'(br_ready), 72'(1));
        check("rst_update", 72'(btb_update), 72'(0));
        check("rst_count", 72'(fifo_count), 72'(0));
        check("rst_busy", 72'(flush_busy), 72'(0));
        check("rst_clear", 72'(btb_clear), 72'(0));

        // 2: distinct sets issue on consecutive cycles, in order
        base = obs_cyc.size();
        push(32'h100, 32'h1100, 1'b0);
        push(32'h104, 32'h2104, 1'b1);
        push(32'h108, 32'h3108, 1'b0);
        idle(6);
        check("t2_issued", 72'(obs_cyc.size() - base), 72'(3));
        if (obs_cyc.size() >= base + 3) begin
            check("t2_gap0", 72'(obs_cyc[base+1] - obs_cyc[base]), 72'(1));
            check("t2_gap1", 72'(obs_cyc[base+2] - obs_cyc[base+1]), 72'(1));
        end
        check("t2_drain", 72'(exp_q.size()), 72'(0));

        // 3: same set back to back -> one bubble
`ifdef BTB_SCHED_STATS_EN
        h0 = stat_hazard;
`endif
        base = obs_cyc.size();
        push(32'h100, 32'hA100, 1'b1);
        push(32'h120, 32'hA120, 1'b0);
        idle(6);
        check("t3_issued", 72'(obs_cyc.size() - base), 72'(2));
        if (obs_cyc.size() >= base + 2) begin
            check("t3_gap", 72'(obs_cyc[base+1] - obs_cyc[base]), 72'(2));
        end
`ifdef BTB_SCHED_STATS_EN
        check("t3_stat_hazard", 72'(stat_hazard - h0), 72'(1));
`endif

        // 4: repeated same-set hazards fill the queue
        for (int k = 0; k < 7; k++) begin
            push(32'h200 + 32'(k) * 32'h20, 32'hB000 + 32'(k), k[0]);
        end
        br_valid = 1'b1;
        br_pc = 32'h2e0;
        br_target = 32'hB007;
        br_mispredicted = 1'b1;
        #1;
        check("t4_full_count", 72'(fifo_count), 72'(4));
        check("t4_full_ready", 72'(br_ready), 72'(0));
        step(1);
        check("t4_ready_back", 72'(br_ready), 72'(1));
        check("t4_count_after_pop", 72'(fifo_count), 72'(3));
        push(32'h2e0, 32'hB007, 1'b1);
        idle(24);
        check("t4_drain", 72'(exp_q.size()), 72'(0));

        // 5: flush discards queued entries and sweeps all sets
        for (int k = 0; k < 5; k++) begin
            push(32'h400 + 32'(k) * 32'h20, 32'hC000 + 32'(k), 1'b0);
        end
        check("t5_queued", 72'(fifo_count), 72'(3));
        flush_req = 1'b1;
        br_valid = 1'b1;
        br_pc = 32'h500;
        br_target = 32'hC500;
        #1;
        check("t5_flush_wins", 72'(br_ready), 72'(0));
        exp_q.delete();
        base = clr_q.size();
        step(1);
        flush_req = 1'b0;
        br_valid = 1'b0;
        check("t5_busy", 72'(flush_busy), 72'(1));
        check("t5_count0", 72'(fifo_count), 72'(0));
        check("t5_clear_first", 72'({btb_clear, btb_clear_index}), 72'({1'b1, 3'd0}));
        step(8);
        check("t5_busy_done", 72'(flush_busy), 72'(0));
        check("t5_clear_done", 72'(btb_clear), 72'(0));
        check("t5_clear_cycles", 72'(clr_q.size() - base), 72'(8));
        for (int i = 0; i < 8 && base + i < clr_q.size(); i++) begin
            check("t5_clear_idx", 72'(clr_q[base+i]), 72'(i));
        end
        check("t5_ready", 72'(br_ready), 72'(1));
        idle(4);

        // 6a: flush during sweep restarts at set 0
        base = clr_q.size();
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        step(5);
        check("t6_at5", 72'(btb_clear_index), 72'(5));
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        check("t6_restart", 72'({btb_clear, btb_clear_index}), 72'({1'b1, 3'd0}));
        step(7);
        check("t6_last", 72'({flush_busy, btb_clear_index}), 72'({1'b1, 3'd7}));
        step(1);
        check("t6_done", 72'(flush_busy), 72'(0));
        check("t6_clear_cycles", 72'(clr_q.size() - base), 72'(14));
        for (int i = 0; i < 14 && base + i < clr_q.size(); i++) begin
            check("t6_clear_idx", 72'(clr_q[base+i]), 72'((i < 6) ? i : i - 6));
        end

        // 6b: async reset mid-sweep aborts immediately
        base = clr_q.size();
        flush_req = 1'b1;
        step(1);
        flush_req = 1'b0;
        step(3);
        check("t6_at3", 72'(btb_clear_index), 72'(3));
        rst = 1'b1;
        #1;
        check("t6_rst_clear", 72'(btb_clear), 72'(0));
        check("t6_rst_busy", 72'(flush_busy), 72'(0));
        check("t6_rst_index", 72'(btb_clear_index), 72'(0));
        check("t6_rst_ready", 72'(br_ready), 72'(1));
`ifdef BTB_SCHED_STATS_EN
        check("t6_rst_stat", 72'({stat_issued, stat_hazard}), 72'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        check("t6_abandoned", 72'(clr_q.size() - base), 72'(3));
        check("t6_idle_clear", 72'(btb_clear), 72'(0));
        check("final_drain", 72'(exp_q.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
